trdb_word_buffer: RTL and testbench

TRDB_WORD_BUFFER -- requirements
Module: trdb_word_buffer

---
 rtl/trdb_pkg.sv | 19 +
 rtl/trdb_word_buffer_if.sv | 16 +
 rtl/trdb_sync_fifo.sv | 45 ++++
 rtl/trdb_word_buffer.sv | 106 ++++++++++
 tb/tb_trdb_word_buffer.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/trdb_pkg.sv
// Shared types and constants for the trace word buffer: control states and
// the overflow marker layout.
package trdb_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DROP = 2'd1,
    MARK = 2'd2
  } trdb_state_e;

  localparam logic [1:0]  TRDB_OVF_TAG = 2'b11;
  localparam logic [15:0] TRDB_CNT_MAX = 16'hFFFF;

  // Marker word: {dropped count, 9 reserved zeros, overflow tag, source id}
  function automatic logic [31:0] trdb_marker(input logic [15:0] cnt, input logic [4:0] id);
    return {cnt, 9'b0, TRDB_OVF_TAG, id};
  endfunction

endpackage

// File: rtl/trdb_word_buffer_if.sv
// Push/pop bus between the buffer control logic and its storage FIFO.
interface trdb_word_buffer_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  logic                     push;
  logic                     pop;
  logic [WIDTH-1:0]         wdata;
  logic [WIDTH-1:0]         rdata;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   level;

  modport master (output push, pop, wdata, input rdata, full, empty, level);
  modport slave  (input push, pop, wdata, output rdata, full, empty, level);
endinterface

// File: rtl/trdb_sync_fifo.sv
// First-fall-through synchronous FIFO; the head word is visible while not empty
// and reads as zero when empty.
module trdb_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  trdb_word_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit separates full (MSBs differ) from empty (all equal)
  assign bus.empty = (wr_ptr_reg == rd_ptr_reg);
  assign bus.full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign bus.level = wr_ptr_reg - rd_ptr_reg;

  // Full is judged before the pop, so push and pop together on a full FIFO succeed
  assign do_pop  = bus.pop && !bus.empty;
  assign do_push = bus.push && (!bus.full || do_pop);

  assign bus.rdata = bus.empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= bus.wdata;
  end

endmodule

// File: rtl/trdb_word_buffer.sv
// Trace word buffer: drops words on overflow, counts them, and once the buffer
// has drained to half full inserts a marker word carrying the drop count.
module trdb_word_buffer
  import trdb_pkg::*;
#(
  parameter int          DEPTH = 16,
  parameter int unsigned ID    = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic [31:0]              word_i,
  input  logic                     word_valid_i,
  output logic [31:0]              data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  output logic [15:0]              drop_cnt_o
);
  localparam int         LW     = $clog2(DEPTH) + 1;
  localparam logic [4:0] SRC_ID = ID[4:0];
  localparam logic [LW-1:0] HALF = LW'(DEPTH / 2);

  trdb_state_e   state_reg, state_next;
  logic [15:0]   drop_cnt_reg, drop_cnt_next;
  logic          overflow_reg, overflow_next;
  logic          flush;
  logic          pop;
  logic          space;
  logic          drop;
  logic [LW-1:0] post_level;

  trdb_word_buffer_if #(.WIDTH(32), .DEPTH(DEPTH)) fifo_bus ();

  trdb_sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_i (flush),
    .bus   (fifo_bus)
  );

  assign flush = rst_i || clear_i;
  assign pop   = !fifo_bus.empty && ready_i;
  assign space = !fifo_bus.full || pop;
  // In DROP and MARK nothing from upstream is stored, so only the pop moves the level
  assign post_level = fifo_bus.level - LW'(pop);

  assign fifo_bus.pop = pop;

  always_comb begin
    state_next     = state_reg;
    drop_cnt_next  = drop_cnt_reg;
    overflow_next  = overflow_reg;
    drop           = 1'b0;
    fifo_bus.push  = 1'b0;
    fifo_bus.wdata = word_i;
    case (state_reg)
      RUN: begin
        if (word_valid_i) begin
          if (space) begin
            fifo_bus.push = 1'b1;
          end else begin
            drop          = 1'b1;
            overflow_next = 1'b1;
            state_next    = DROP;
          end
        end
      end
      DROP: begin
        drop = word_valid_i;
        if (post_level <= HALF) state_next = MARK;
      end
      MARK: begin
        if (word_valid_i) begin
          drop = 1'b1;
        end else if (space) begin
          fifo_bus.push  = 1'b1;
          fifo_bus.wdata = trdb_marker(drop_cnt_reg, SRC_ID);
          drop_cnt_next  = '0;
          state_next     = RUN;
        end
      end
      default: state_next = RUN;
    endcase
    if (drop && (drop_cnt_reg != TRDB_CNT_MAX)) drop_cnt_next = drop_cnt_reg + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      state_reg    <= RUN;
      drop_cnt_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      drop_cnt_reg <= drop_cnt_next;
      overflow_reg <= overflow_next;
    end
  end

  assign data_o     = fifo_bus.rdata;
  assign valid_o    = !fifo_bus.empty;
  assign level_o    = fifo_bus.level;
  assign overflow_o = overflow_reg;
  assign drop_cnt_o = drop_cnt_reg;

endmodule

// File: tb/tb_trdb_word_buffer.sv
// Self-checking bench for trdb_word_buffer: a cycle model holds the expected
// buffer contents as a queue; every cycle the DUT outputs are compared to it.
module tb_trdb_word_buffer;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int S_RUN = 0, S_DROP = 1, S_MARK = 2;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          clear_i = 1'b0;
  logic [31:0]   word_i = '0;
  logic          word_valid_i = 1'b0;
  logic [31:0]   data_o;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [LW-1:0] level_o;
  logic          overflow_o;
  logic [15:0]   drop_cnt_o;

  logic [31:0] exp_q[$];
  int          m_state = S_RUN;
  logic [15:0] m_cnt = '0;
  logic        m_ovf = 1'b0;
  logic [31:0] last_pop = '0;
  logic [31:0] word_seq = 32'hA000_0000;
  int          n_checks = 0;
  int          n_pass = 0;

  trdb_word_buffer #(.DEPTH(DEPTH), .ID(1)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .word_i       (word_i),
    .word_valid_i (word_valid_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .level_o      (level_o),
    .overflow_o   (overflow_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic bump();
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
  endtask

  // Expected behaviour of one clock edge, given the inputs driven before it
  task automatic model_edge(input logic wv, input logic [31:0] w, input logic rdy,
                            input logic clr, input logic rst);
    int          n;
    bit          pop, space;
    logic [31:0] tmp;
    n     = exp_q.size();
    pop   = rdy && (n > 0);
    space = (n < DEPTH) || pop;
    if (rst || clr) begin
      exp_q.delete();
      m_state = S_RUN;
      m_cnt   = '0;
      m_ovf   = 1'b0;
      return;
    end
    if (pop) tmp = exp_q.pop_front();
    case (m_state)
      S_RUN: if (wv) begin
        if (space) exp_q.push_back(w);
        else begin bump(); m_ovf = 1'b1; m_state = S_DROP; end
      end
      S_DROP: begin
        if (wv) bump();
        if (exp_q.size() <= DEPTH / 2) m_state = S_MARK;
      end
      default: begin
        if (wv) bump();
        else if (space) begin
          exp_q.push_back({m_cnt, 9'b0, 2'b11, 5'd1});
          m_cnt   = '0;
          m_state = S_RUN;
        end
      end
    endcase
  endtask

  // One cycle: compare outputs against the model, drive inputs, advance both
  task automatic step(input logic wv, input logic rdy, input logic clr = 1'b0,
                      input logic rst = 1'b0);
    logic [31:0] w;
    w        = word_seq;
    word_seq = word_seq + 32'd1;
    check("valid", {31'b0, valid_o}, {31'b0, exp_q.size() != 0});
    check("data", data_o, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
    check("level", {{(32-LW){1'b0}}, level_o}, exp_q.size());
    check("overflow", {31'b0, overflow_o}, {31'b0, m_ovf});
    check("drop_cnt", {16'b0, drop_cnt_o}, {16'b0, m_cnt});
    if (valid_o && rdy) begin
      last_pop = data_o;
      $display("pop  %h  level %0d", data_o, level_o);
    end
    word_i       = w;
    word_valid_i = wv;
    ready_i      = rdy;
    clear_i      = clr;
    rst_i        = rst;
    @(posedge clk_i);
    model_edge(wv, w, rdy, clr, rst);
    @(negedge clk_i);
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Three words streamed through with the sink always ready
    step(1, 1); step(1, 1); step(1, 1);
    repeat (3) step(0, 1);
    check("abc_level", {{(32-LW){1'b0}}, level_o}, 32'd0);

    // Overfill: 20 words into a 16-deep buffer with the sink stalled
    repeat (20) step(1, 0);
    check("ovf_level", {{(32-LW){1'b0}}, level_o}, 32'd16);
    check("ovf_cnt", {16'b0, drop_cnt_o}, 32'd4);
    check("ovf_flag", {31'b0, overflow_o}, 32'd1);

    // Drain to half, then one idle cycle emits the marker
    repeat (8) step(0, 1);
    step(0, 0);
    check("mark_cnt", {16'b0, drop_cnt_o}, 32'd0);
    check("mark_ovf", {31'b0, overflow_o}, 32'd1);
    check("mark_level", {{(32-LW){1'b0}}, level_o}, 32'd9);
    repeat (9) step(0, 1);
    check("marker4", last_pop, 32'h0004_0061);

    // Full buffer with simultaneous push and pop
    step(0, 0, 1);
    repeat (16) step(1, 0);
    step(1, 1);
    check("fullpp_level", {{(32-LW){1'b0}}, level_o}, 32'd16);
    check("fullpp_cnt", {16'b0, drop_cnt_o}, 32'd0);
    check("fullpp_ovf", {31'b0, overflow_o}, 32'd0);

    // Words arriving while a marker is pending are counted into it
    repeat (2) step(1, 0);
    repeat (8) step(0, 1);
    repeat (3) step(1, 0);
    check("pend_cnt", {16'b0, drop_cnt_o}, 32'd5);
    step(0, 0);
    repeat (9) step(0, 1);
    check("marker5", last_pop, 32'h0005_0061);

    // Clear dominates a same-cycle push and pop
    repeat (5) step(1, 0);
    step(1, 1, 1);
    check("clr_level", {{(32-LW){1'b0}}, level_o}, 32'd0);
    check("clr_valid", {31'b0, valid_o}, 32'd0);
    check("clr_ovf", {31'b0, overflow_o}, 32'd0);

    // Random traffic with occasional clear and reset
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 99) == 0), ($urandom_range(0, 119) == 0));
    end
    repeat (DEPTH + 2) step(0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
